// File: rtl/wc_pkg.sv
// Shared definitions for the streaming Winograd-successor convolution engine.
//   - Default geometry (DW/M/R) used by wc_stream_conv and wc_mac_lane.
//   - state_e: tile FSM states FILL / COMPUTE / OUT / NEXT (2-bit encoding).
//   - clog2(): constant-evaluable ceiling log2 for port/register sizing.
//   - narrow(): reduces a wide signed accumulator to a dw-bit result.
// Build option: WC_SAT_EN
//   defined   -> narrow() saturates to [-2^(dw-1), 2^(dw-1)-1]
//   undefined -> narrow() wraps (keeps the low dw bits, two's complement)
package wc_pkg;

  localparam int DW_DEF = 10;
  localparam int M_DEF  = 4;
  localparam int R_DEF  = 4;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUT     = 2'd2,
    ST_NEXT    = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // The result is returned sign-extended to 64 bits; callers keep the low
  // dw bits. Accumulators must not exceed 64 bits.
  function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                               input int unsigned dw);
`ifdef WC_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    // Drop everything above bit dw-1, then re-sign-extend from bit dw-1.
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/wc_mac_lane.sv
// One output lane of the convolution engine: y[i] accumulates x[i+k]*g[k]
// over the R tap cycles of a tile.
// Ports:
//   clk     rising-edge clock
//   rst_ni  asynchronous active-low reset (clears the accumulator)
//   en_i    accumulate this cycle
//   clr_i   with en_i: start a new sum (acc = x*g instead of acc + x*g)
//   x_i     signed sample for this tap
//   g_i     signed tap coefficient
//   y_o     narrowed result of the held accumulator (sat or wrap, see wc_pkg)
module wc_mac_lane
  import wc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 2 * DW_DEF + clog2(R_DEF)
) (
  input  logic                 clk,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] g_i,
  output logic signed [DW-1:0] y_o
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   base;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;

  assign prod = x_i * g_i;
  // Clearing is folded into the first MAC so no dead cycle is spent on it.
  assign base = clr_i ? '0 : acc_q;

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = base + AW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The accumulator holds its value through OUT, so the result is stable
  // for the whole handshake without a separate output register.
  assign y_o = DW'(narrow(64'(acc_q), DW));

endmodule

// File: rtl/wc_stream_conv.sv
// Streaming 1-D convolution engine: M outputs per tile from R runtime-loaded
// taps, tile input N = M+R-1. The R-1 sample overlap between consecutive
// tiles is kept internally, so after the first tile only M new samples are
// needed per tile.
// Ports:
//   clk                     rising-edge clock
//   rst                     asynchronous active-low reset
//   k_we/k_idx/k_data       kernel tap write (ignored while busy)
//   s_valid/s_ready/s_data  sample stream in; s_first restarts a row
//   m_valid/m_ready/m_data  result tile out; y[0] in the MSB field
//   busy                    high during the R-cycle COMPUTE phase
// Build option: WC_SAT_EN selects saturating narrowing (default: wrap).
module wc_stream_conv
  import wc_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int M  = M_DEF,
  parameter int R  = R_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    k_we,
  input  logic [clog2(R)-1:0]     k_idx,
  input  logic signed [DW-1:0]    k_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_first,
  input  logic signed [DW-1:0]    s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [M*DW-1:0]         m_data,
  output logic                    busy
);

  localparam int N  = M + R - 1;
  localparam int AW = 2 * DW + clog2(R);
  localparam int KW = clog2(R);
  localparam int CW = clog2(N + 1);
  localparam int IW = clog2(N);

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [KW-1:0]        kcnt_q, kcnt_d;
  logic                 rdy_en_q;
  logic signed [DW-1:0] buf_q [N];
  logic signed [DW-1:0] buf_d [N];
  logic signed [DW-1:0] g_q [R];
  logic signed [DW-1:0] g_d [R];
  logic signed [DW-1:0] tap_g;
  logic signed [DW-1:0] y [M];

  logic s_acc;
  logic last_tap;
  logic tile_full;

  assign s_acc     = s_valid & s_ready;
  assign last_tap  = (kcnt_q == KW'(R - 1));
  // True when the sample being accepted now is the Nth of the tile.
  assign tile_full = (count_q == CW'(N - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL, ST_NEXT: begin
        if (s_acc) begin
          if (s_first) begin
            state_d = ST_FILL;
          end else if (tile_full) begin
            state_d = ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        if (last_tap) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) state_d = ST_NEXT;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_FILL, ST_NEXT: s_ready = rdy_en_q;
      ST_COMPUTE:       busy    = 1'b1;
      ST_OUT:           m_valid = 1'b1;
      default:          ;
    endcase
  end

  // ---------------- Sample buffer, fill count, tap counter ----------------
  always_comb begin
    count_d = count_q;
    kcnt_d  = kcnt_q;
    for (int j = 0; j < N; j++) begin
      buf_d[j] = buf_q[j];
    end
    case (state_q)
      ST_FILL, ST_NEXT: begin
        if (s_acc) begin
          if (s_first) begin
            buf_d[0] = s_data;
            count_d  = CW'(1);
          end else begin
            buf_d[IW'(count_q)] = s_data;
            count_d             = count_q + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        kcnt_d = last_tap ? '0 : kcnt_q + 1'b1;
      end
      ST_OUT: begin
        // Slide the window by M: the last R-1 samples become x[0..R-2].
        if (m_ready) begin
          for (int j = 0; j < R - 1; j++) begin
            buf_d[j] = buf_q[j + M];
          end
          count_d = CW'(R - 1);
        end
      end
      default: ;
    endcase
  end

  // Taps are frozen during COMPUTE so a tile never mixes two kernels.
  always_comb begin
    for (int j = 0; j < R; j++) begin
      g_d[j] = g_q[j];
    end
    if (k_we && (state_q != ST_COMPUTE)) begin
      g_d[k_idx] = k_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      kcnt_q   <= '0;
      rdy_en_q <= 1'b0;
      for (int j = 0; j < N; j++) begin
        buf_q[j] <= '0;
      end
      for (int j = 0; j < R; j++) begin
        g_q[j] <= (j == 0) ? DW'(1) : '0;
      end
    end else begin
      count_q  <= count_d;
      kcnt_q   <= kcnt_d;
      // Holds s_ready low for the first cycle after reset release.
      rdy_en_q <= 1'b1;
      for (int j = 0; j < N; j++) begin
        buf_q[j] <= buf_d[j];
      end
      for (int j = 0; j < R; j++) begin
        g_q[j] <= g_d[j];
      end
    end
  end

  // ---------------- MAC lanes ----------------
  assign tap_g = g_q[kcnt_q];

  for (genvar gi = 0; gi < M; gi++) begin : g_lane
    logic [IW-1:0] xi;
    assign xi = IW'(gi) + IW'(kcnt_q);

    wc_mac_lane #(
      .DW (DW),
      .AW (AW)
    ) u_lane (
      .clk    (clk),
      .rst_ni (rst),
      .en_i   (state_q == ST_COMPUTE),
      .clr_i  (kcnt_q == '0),
      .x_i    (buf_q[xi]),
      .g_i    (tap_g),
      .y_o    (y[gi])
    );

    assign m_data[(M-1-gi)*DW +: DW] = y[gi];
  end

endmodule

// File: tb/tb_wc_stream_conv.sv
module tb_wc_stream_conv;

  localparam int DW = 10;
  localparam int M  = 4;
  localparam int R  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 k_we = 1'b0;
  logic [1:0]           k_idx = '0;
  logic signed [DW-1:0] k_data = '0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic                 s_first = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [M*DW-1:0]      m_data;
  logic                 busy;

  int assertions = 0;
  int failures   = 0;

  wc_stream_conv #(.DW(DW), .M(M), .R(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .k_we    (k_we),
    .k_idx   (k_idx),
    .k_data  (k_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_first (s_first),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [M*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(a), DW'(b), DW'(c), DW'(d)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(input int g0, input int g1, input int g2, input int g3);
    int g [4];
    g = '{g0, g1, g2, g3};
    for (int i = 0; i < 4; i++) begin
      k_we = 1'b1; k_idx = 2'(i); k_data = DW'(g[i]);
      @(posedge clk); #1;
    end
    k_we = 1'b0;
  endtask

  // Returns one time unit after the accepting clock edge.
  task automatic send_sample(input int d, input logic f);
    int cyc;
    cyc = 0;
    s_valid = 1'b1; s_data = DW'(d); s_first = f;
    @(negedge clk);
    while (s_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (s_ready !== 1'b1) begin
      assertions++; failures++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, cyc);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  task automatic stream7(input int v [7], input logic first);
    for (int i = 0; i < 7; i++) send_sample(v[i], (i == 0) ? first : 1'b0);
  endtask

  // Returns at a negedge where m_valid is high.
  task automatic wait_tile(input string tag, output logic [M*DW-1:0] data);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (m_valid !== 1'b1) begin
      assertions++; failures++;
      $display("FAIL %s_tile_timeout: m_valid=%b, required 1", tag, m_valid);
    end
    data = m_data;
    $display("tile %s: m_data=%h", tag, data);
  endtask

  task automatic ack_tile();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  // Identity-kernel tile with latency checks; shared by the first and last tests.
  task automatic run_identity_tile(input string tag, input logic first);
    logic [M*DW-1:0] exp;
    exp = pack4(2, -10, 3, 4);
    stream7('{2, -10, 3, 4, -13, -18, -16}, first);
    for (int c = 1; c <= R; c++) begin
      @(negedge clk);
      assertions++;
      if (busy !== 1'b1 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s_latency_busy cycle %0d: busy=%b m_valid=%b, required busy=1 m_valid=0", tag, c, busy, m_valid);
      end
    end
    @(negedge clk);
    assertions++;
    if (m_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_latency_valid: m_valid=%b busy=%b, required m_valid=1 busy=0", tag, m_valid, busy);
    end
    assertions++;
    if (m_data !== exp) begin
      failures++;
      $display("FAIL %s_identity_data: got %h, required %h", tag, m_data, exp);
    end
    $display("tile %s: m_data=%h", tag, m_data);
    ack_tile();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
    assertions++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    assertions++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy); end
    assertions++;
    if (m_data !== '0) begin failures++; $display("FAIL reset_m_data: got %h, required 0", m_data); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    assertions++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL release_s_ready_early: got %b, required 0", s_ready); end
    @(negedge clk);
    assertions++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL release_s_ready: got %b, required 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    run_identity_tile("t1", 1'b1);
  endtask

  task automatic test_kernel_next();
    logic [M*DW-1:0] d;
    load_kernel(1, 1, 1, 1);
    stream7('{2, -10, 3, 4, -13, -18, -16}, 1'b1);
    wait_tile("t2a", d);
    assertions++;
    if (d !== pack4(-1, -16, -24, -43)) begin
      failures++; $display("FAIL ones_kernel: got %h, required %h", d, pack4(-1, -16, -24, -43));
    end
    ack_tile();
    for (int i = 0; i < 4; i++) send_sample(5, 1'b0);
    wait_tile("t2b", d);
    assertions++;
    if (d !== pack4(-42, -24, -1, 20)) begin
      failures++; $display("FAIL next_overlap: got %h, required %h", d, pack4(-42, -24, -1, 20));
    end
  endtask

  // Continues on the unacknowledged tile left by test_kernel_next.
  task automatic test_backpressure();
    logic [M*DW-1:0] exp;
    exp = pack4(-42, -24, -1, 20);
    m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      assertions++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp) begin
        failures++;
        $display("FAIL backpressure cycle %0d: m_valid=%b s_ready=%b m_data=%h, required 1/0/%h", c, m_valid, s_ready, m_data, exp);
      end
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    assertions++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: s_ready=%b m_valid=%b, required 1/0", s_ready, m_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [M*DW-1:0] d;
    logic [M*DW-1:0] exp_a;
    logic [M*DW-1:0] exp_b;
`ifdef WC_SAT_EN
    exp_a = pack4(511, 511, 511, 511);
    exp_b = pack4(511, 511, 511, 511);
`else
    // 500*511 = 255500 wraps to -500; 511*511 = 261121 wraps to 1.
    exp_a = pack4(-500, -500, -500, -500);
    exp_b = pack4(1, 1, 1, 1);
`endif
    do_reset();
    load_kernel(500, 0, 0, 0);
    stream7('{511, 511, 511, 511, 511, 511, 511}, 1'b1);
    wait_tile("t4a", d);
    assertions++;
    if (d !== exp_a) begin failures++; $display("FAIL narrow_500: got %h, required %h", d, exp_a); end
    ack_tile();
    load_kernel(511, 0, 0, 0);
    for (int i = 0; i < 4; i++) send_sample(511, 1'b0);
    wait_tile("t4b", d);
    assertions++;
    if (d !== exp_b) begin failures++; $display("FAIL narrow_511: got %h, required %h", d, exp_b); end
    ack_tile();
  endtask

  task automatic test_first_restart();
    logic [M*DW-1:0] d;
    do_reset();
    for (int i = 0; i < 3; i++) send_sample(9, 1'b0);
    send_sample(1, 1'b1);
    for (int i = 2; i <= 7; i++) send_sample(i, 1'b0);
    // Now in the first COMPUTE cycle: this write to tap 3 must be dropped.
    k_we = 1'b1; k_idx = 2'd3; k_data = DW'(7);
    @(posedge clk); #1;
    k_we = 1'b0;
    wait_tile("t5a", d);
    assertions++;
    if (d !== pack4(1, 2, 3, 4)) begin
      failures++; $display("FAIL first_restart: got %h, required %h", d, pack4(1, 2, 3, 4));
    end
    ack_tile();
    for (int i = 0; i < 4; i++) send_sample(1, 1'b0);
    wait_tile("t5b", d);
    assertions++;
    if (d !== pack4(5, 6, 7, 1)) begin
      failures++; $display("FAIL compute_kwrite_ignored: got %h, required %h", d, pack4(5, 6, 7, 1));
    end
    ack_tile();
  endtask

  task automatic test_reset_compute();
    load_kernel(1, 1, 1, 1);
    stream7('{2, -10, 3, 4, -13, -18, -16}, 1'b1);
    @(negedge clk);
    assertions++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midreset_pre_busy: got %b, required 1", busy); end
    rst = 1'b0;
    #1;
    assertions++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b m_valid=%b s_ready=%b, required 0/0/0", busy, m_valid, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    // No s_first: also confirms the fill count returned to zero.
    run_identity_tile("t6", 1'b0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_kernel_next();
    test_backpressure();
    test_saturation();
    test_first_restart();
    test_reset_compute();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
